// File: rtl/lcd_pkg.sv
// Shared LCD SPI constants: FSM encodings and SPI mode-0 line levels, used by both rx and tx paths.
// No logic; constants only.
package lcd_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Mode 0: SCL idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic SCL_IDLE = SPI_CPOL;
  localparam logic SDA_IDLE = 1'b0;
  localparam logic CSN_IDLE = 1'b1;

  localparam int         SPI_BITS     = 8;
  localparam logic [2:0] BIT_CNT_INIT = 3'(SPI_BITS - 1);

endpackage

// File: rtl/cdc_sync.sv
// Single-bit multi-flop synchronizer; latency DEPTH clk cycles, no backpressure.
// Reset loads every stage with RST_VAL so the output shows the line's idle level.
module cdc_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {DEPTH{RST_VAL}};
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/lcd_spi_rx.sv
// SPI mode-0 byte receiver from the LCD; byte appears SYNC_STAGES+1 clk after the 8th SCL rise.
// Single holding register with valid/ready; a byte completing while the holder is stalled is dropped and flagged in rx_ovf.
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_scl,
  input  logic       spi_sda,
  input  logic       spi_csn,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       rx_ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  logic       w_scl_s;
  logic       w_sda_s;
  logic       w_csn_s;
  logic       w_scl_rise;
  logic       w_done;
  logic       w_load;
  logic       w_drop;
  logic [7:0] w_byte;

  logic [0:0] r_state;
  logic [2:0] r_cnt;
  logic [6:0] r_shreg;
  logic       r_first_pend;
  logic       r_scl_d;
  logic [7:0] r_data;
  logic       r_first;
  logic       r_vld;
  logic       r_ovf;

  cdc_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(SCL_IDLE)) u_sync_scl (
    .clk (clk),
    .rst (rst),
    .i_d (spi_scl),
    .o_q (w_scl_s)
  );

  cdc_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(SDA_IDLE)) u_sync_sda (
    .clk (clk),
    .rst (rst),
    .i_d (spi_sda),
    .o_q (w_sda_s)
  );

  cdc_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(CSN_IDLE)) u_sync_csn (
    .clk (clk),
    .rst (rst),
    .i_d (spi_csn),
    .o_q (w_csn_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_d <= SCL_IDLE;
    end else begin
      r_scl_d <= w_scl_s;
    end
  end

  assign w_scl_rise = w_scl_s & ~r_scl_d;

  // CSN deassertion outranks a coincident SCL rise, so a frame end never produces a byte.
  assign w_done = (r_state == ST_SHIFT) && !w_csn_s && w_scl_rise && (r_cnt == 3'd0);
  assign w_byte = {r_shreg, w_sda_s};
  assign w_load = w_done && (!r_vld || rx_rdy);
  assign w_drop = w_done && r_vld && !rx_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= BIT_CNT_INIT;
      r_shreg      <= '0;
      r_first_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_csn_s) begin
            r_state      <= ST_SHIFT;
            r_cnt        <= BIT_CNT_INIT;
            r_shreg      <= '0;
            r_first_pend <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_csn_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= BIT_CNT_INIT;
            r_shreg <= '0;
          end else if (w_scl_rise) begin
            r_shreg <= {r_shreg[5:0], w_sda_s};
            r_cnt   <= r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              r_first_pend <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_first <= 1'b0;
      r_vld   <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_byte;
      r_first <= r_first_pend;
      r_vld   <= 1'b1;
    end else if (r_vld && rx_rdy) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign rx_data  = r_data;
  assign rx_first = r_first;
  assign rx_vld   = r_vld;
  assign rx_ovf   = r_ovf;
  assign busy     = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: SCL at clk/8, accepted bytes logged as {first, data}.
module tb_lcd_spi_rx;

  logic       clk;
  logic       rst;
  logic       spi_scl;
  logic       spi_sda;
  logic       spi_csn;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       rx_vld;
  logic       rx_rdy;
  logic       rx_ovf;
  logic       ovf_clr;
  logic       busy;

  int n_chk;
  int n_fail;
  logic [8:0] got_q[$];

  lcd_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_scl  (spi_scl),
    .spi_sda  (spi_sda),
    .spi_csn  (spi_csn),
    .rx_data  (rx_data),
    .rx_first (rx_first),
    .rx_vld   (rx_vld),
    .rx_rdy   (rx_rdy),
    .rx_ovf   (rx_ovf),
    .ovf_clr  (ovf_clr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so the negedge view matches what the next edge samples.
  always @(negedge clk) begin
    if (rst && rx_vld && rx_rdy) got_q.push_back({rx_first, rx_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    spi_csn = 1'b0;
    tick(6);
  endtask

  task automatic end_frame();
    tick(6);
    spi_csn = 1'b1;
    tick(8);
  endtask

  // Sends the top nbits of b. With collide set, rx_rdy rises exactly in the cycle the last bit completes.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit collide,
                           input logic [7:0] held, input logic [7:0] nxt);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sda = b[i];
      tick(4);
      spi_scl = 1'b1;
      if (collide && i == 8 - nbits) begin
        tick(2);
        rx_rdy = 1'b1;
        @(negedge clk);
        check_eq("col_pre_data", {24'd0, rx_data}, {24'd0, held});
        check_eq("col_pre_vld", {31'd0, rx_vld}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("col_post_data", {24'd0, rx_data}, {24'd0, nxt});
        check_eq("col_post_first", {31'd0, rx_first}, 32'd0);
        check_eq("col_post_ovf", {31'd0, rx_ovf}, 32'd0);
        tick(1);
      end else begin
        tick(4);
      end
      spi_scl = 1'b0;
    end
  endtask

  task automatic check_q(input string tag, input int n,
                         input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
    logic [8:0] exp_v[3];
    exp_v[0] = e0;
    exp_v[1] = e1;
    exp_v[2] = e2;
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < got_q.size()) ? {23'd0, got_q[i]} : 32'hDEAD, {23'd0, exp_v[i]});
    end
    got_q.delete();
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b0;
    spi_scl = 1'b0;
    spi_sda = 1'b0;
    spi_csn = 1'b1;
    rx_rdy  = 1'b0;
    ovf_clr = 1'b0;
    tick(4);
    check_eq("rst_data", {24'd0, rx_data}, 32'h00);
    check_eq("rst_vld", {31'd0, rx_vld}, 32'd0);
    check_eq("rst_first", {31'd0, rx_first}, 32'd0);
    check_eq("rst_ovf", {31'd0, rx_ovf}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick(4);

    // Single byte
    rx_rdy = 1'b1;
    start_frame();
    check_eq("single_busy", {31'd0, busy}, 32'd1);
    send_bits(8'hA5, 8, 1'b0, 8'h00, 8'h00);
    end_frame();
    check_q("single", 1, {1'b1, 8'hA5}, 9'h0, 9'h0);
    check_eq("single_ovf", {31'd0, rx_ovf}, 32'd0);
    check_eq("single_idle", {31'd0, busy}, 32'd0);
    check_eq("single_vld_low", {31'd0, rx_vld}, 32'd0);

    // Burst in one frame
    start_frame();
    send_bits(8'h3C, 8, 1'b0, 8'h00, 8'h00);
    check_eq("burst_busy0", {31'd0, busy}, 32'd1);
    send_bits(8'h81, 8, 1'b0, 8'h00, 8'h00);
    check_eq("burst_busy1", {31'd0, busy}, 32'd1);
    send_bits(8'hFF, 8, 1'b0, 8'h00, 8'h00);
    check_eq("burst_busy2", {31'd0, busy}, 32'd1);
    end_frame();
    check_q("burst", 3, {1'b1, 8'h3C}, {1'b0, 8'h81}, {1'b0, 8'hFF});

    // Back-pressure overflow, then clear
    rx_rdy = 1'b0;
    start_frame();
    send_bits(8'h11, 8, 1'b0, 8'h00, 8'h00);
    send_bits(8'h22, 8, 1'b0, 8'h00, 8'h00);
    end_frame();
    check_eq("bp_data", {24'd0, rx_data}, 32'h11);
    check_eq("bp_vld", {31'd0, rx_vld}, 32'd1);
    check_eq("bp_first", {31'd0, rx_first}, 32'd1);
    check_eq("bp_ovf", {31'd0, rx_ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_eq("bp_ovf_clr", {31'd0, rx_ovf}, 32'd0);
    check_eq("bp_vld_kept", {31'd0, rx_vld}, 32'd1);
    rx_rdy = 1'b1;
    tick(2);
    check_q("bp_drain", 1, {1'b1, 8'h11}, 9'h0, 9'h0);
    check_eq("bp_vld_after", {31'd0, rx_vld}, 32'd0);

    // Abort after 5 bits, then a clean frame
    start_frame();
    send_bits(8'hF0, 5, 1'b0, 8'h00, 8'h00);
    end_frame();
    check_q("abort", 0, 9'h0, 9'h0, 9'h0);
    check_eq("abort_idle", {31'd0, busy}, 32'd0);
    check_eq("abort_vld", {31'd0, rx_vld}, 32'd0);
    start_frame();
    send_bits(8'h5A, 8, 1'b0, 8'h00, 8'h00);
    end_frame();
    check_q("after_abort", 1, {1'b1, 8'h5A}, 9'h0, 9'h0);

    // Accept and complete in the same cycle
    rx_rdy = 1'b0;
    start_frame();
    send_bits(8'h01, 8, 1'b0, 8'h00, 8'h00);
    send_bits(8'h02, 8, 1'b1, 8'h01, 8'h02);
    end_frame();
    check_q("collide", 2, {1'b1, 8'h01}, {1'b0, 8'h02}, 9'h0);
    check_eq("collide_ovf", {31'd0, rx_ovf}, 32'd0);

    // Reset mid-byte with a byte held
    rx_rdy = 1'b0;
    start_frame();
    send_bits(8'h77, 8, 1'b0, 8'h00, 8'h00);
    send_bits(8'hC3, 3, 1'b0, 8'h00, 8'h00);
    check_eq("pre_rst_vld", {31'd0, rx_vld}, 32'd1);
    rst = 1'b0;
    #2;
    check_eq("mid_rst_vld", {31'd0, rx_vld}, 32'd0);
    check_eq("mid_rst_data", {24'd0, rx_data}, 32'h00);
    check_eq("mid_rst_first", {31'd0, rx_first}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_ovf", {31'd0, rx_ovf}, 32'd0);
    spi_csn = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(4);
    check_eq("post_rst_idle", {31'd0, busy}, 32'd0);
    rx_rdy = 1'b1;
    start_frame();
    send_bits(8'hC3, 8, 1'b0, 8'h00, 8'h00);
    end_frame();
    check_q("after_rst", 1, {1'b1, 8'hC3}, 9'h0, 9'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
